// File: rtl/prism_cfg_pkg.sv
// Shared types and widths for the PRISM configuration sequencer.
package prism_cfg_pkg;

  localparam int unsigned ADDR_W       = 6;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned HOLD_DEFAULT = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT,
    ST_LOAD,
    ST_HOLD,
    ST_RUN
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cfg_entry_t;

endpackage

// File: rtl/prism_cfg_seq_if.sv
// Host, staging, control and PRISM debug signals of the configuration sequencer.
interface prism_cfg_seq_if
  import prism_cfg_pkg::*;
#(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic              host_wr;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ready;
  logic              stage_wr;
  logic [ADDR_W-1:0] stage_addr;
  logic [DATA_W-1:0] stage_data;
  logic [CW-1:0]     stage_count;
  logic              stage_full;
  logic              overflow;
  logic              start;
  logic              abort;
  logic              auto_en;
  logic              busy;
  logic              done;
  logic              empty_err;
  logic              dbg_wr;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              fsm_reset;
  logic              fsm_enable;

  modport master (
    output host_wr, host_addr, host_wdata, stage_wr, stage_addr, stage_data,
           start, abort, auto_en,
    input  host_ready, stage_count, stage_full, overflow, busy, done, empty_err,
           dbg_wr, dbg_addr, dbg_wdata, fsm_reset, fsm_enable
  );

  modport slave (
    input  host_wr, host_addr, host_wdata, stage_wr, stage_addr, stage_data,
           start, abort, auto_en,
    output host_ready, stage_count, stage_full, overflow, busy, done, empty_err,
           dbg_wr, dbg_addr, dbg_wdata, fsm_reset, fsm_enable
  );
endinterface

// File: rtl/prism_cfg_fifo.sv
// Staging FIFO of {addr,data} entries; a push while full succeeds only alongside a pop.
module prism_cfg_fifo
  import prism_cfg_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  cfg_entry_t                 push_data,
  input  logic                       pop,
  output cfg_entry_t                 head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  cfg_entry_t    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          wr_en, rd_en;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    wr_en = push && (!full || pop);
    rd_en = pop && !empty;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(wr_en) - CW'(rd_en);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst && !flush) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/prism_cfg_seq.sv
// Sequencer that halts PRISM, replays staged and host debug writes, then restarts it.
module prism_cfg_seq
  import prism_cfg_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned HOLD  = HOLD_DEFAULT
) (
  input logic            clk,
  input logic            rst,
  prism_cfg_seq_if.slave bus
);
  localparam int unsigned HW = $clog2(HOLD + 1);

  state_e            state_q;
  logic [HW-1:0]     hold_cnt_q;
  logic              busy_q, done_q, empty_err_q, overflow_q;
  logic              dbg_wr_q, fsm_reset_q, fsm_enable_q;
  logic [ADDR_W-1:0] dbg_addr_q;
  logic [DATA_W-1:0] dbg_wdata_q;

  cfg_entry_t head, push_entry;
  logic       pop, flush, push_drop, fifo_full, fifo_empty;

  assign push_entry = '{addr: bus.stage_addr, data: bus.stage_data};

  always_comb begin
    flush     = bus.abort && (state_q != ST_IDLE);
    pop       = (state_q == ST_LOAD) && !bus.abort && !bus.host_wr && !fifo_empty;
    push_drop = bus.stage_wr && fifo_full && !pop && !flush;
  end

  prism_cfg_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (bus.stage_wr),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (bus.stage_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      hold_cnt_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      empty_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
      dbg_wr_q     <= 1'b0;
      dbg_addr_q   <= '0;
      dbg_wdata_q  <= '0;
      fsm_reset_q  <= 1'b0;
      fsm_enable_q <= 1'b0;
    end else begin
      dbg_wr_q <= 1'b0;
      done_q   <= 1'b0;
      if (flush) begin
        state_q      <= ST_IDLE;
        hold_cnt_q   <= '0;
        busy_q       <= 1'b0;
        fsm_reset_q  <= 1'b1;
        fsm_enable_q <= 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (bus.host_wr) begin
              dbg_wr_q    <= 1'b1;
              dbg_addr_q  <= bus.host_addr;
              dbg_wdata_q <= bus.host_wdata;
              state_q     <= ST_HOLD;
            end else if (bus.start && !bus.abort) begin
              overflow_q  <= 1'b0;
              empty_err_q <= 1'b0;
              if (!fifo_empty) begin
                state_q <= ST_HALT;
              end else begin
                done_q      <= 1'b1;
                empty_err_q <= 1'b1;
              end
            end
          end
          ST_HALT: begin
            fsm_enable_q <= 1'b0;
            fsm_reset_q  <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= ST_LOAD;
          end
          ST_LOAD: begin
            if (bus.host_wr) begin
              dbg_wr_q    <= 1'b1;
              dbg_addr_q  <= bus.host_addr;
              dbg_wdata_q <= bus.host_wdata;
              state_q     <= ST_HOLD;
            end else if (!fifo_empty) begin
              dbg_wr_q    <= 1'b1;
              dbg_addr_q  <= head.addr;
              dbg_wdata_q <= head.data;
              state_q     <= ST_HOLD;
            end else begin
              state_q <= ST_RUN;
            end
          end
          ST_HOLD: begin
            // busy_q tells a sequence slot apart from a standalone host write.
            if (hold_cnt_q == HW'(HOLD - 1)) begin
              hold_cnt_q <= '0;
              state_q    <= busy_q ? ST_LOAD : ST_IDLE;
            end else begin
              hold_cnt_q <= hold_cnt_q + 1'b1;
            end
          end
          ST_RUN: begin
            fsm_reset_q  <= 1'b0;
            fsm_enable_q <= bus.auto_en;
            done_q       <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
      if (push_drop) overflow_q <= 1'b1;
    end
  end

  assign bus.host_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign bus.stage_full = fifo_full;
  assign bus.overflow   = overflow_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.empty_err  = empty_err_q;
  assign bus.dbg_wr     = dbg_wr_q;
  assign bus.dbg_addr   = dbg_addr_q;
  assign bus.dbg_wdata  = dbg_wdata_q;
  assign bus.fsm_reset  = fsm_reset_q;
  assign bus.fsm_enable = fsm_enable_q;

endmodule

// File: doc/prism_cfg_seq.md
PRISM_CFG_SEQ -- requirements
Module: prism_cfg_seq

Interface
REQ-001 SHALL have parameter DEPTH, default 4: staging FIFO entries, power of two.
REQ-002 SHALL have parameter HOLD, default 2: cycles dbg_addr/dbg_wdata stay stable after each dbg_wr, matching the 2-cycle delayed latch write.
REQ-003 SHALL have port clk  in  1  single clock; every flop is clocked on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port host_wr / host_addr / host_wdata  in  1/6/32  host write request, 32-bit writes only.
REQ-006 SHALL have port host_ready  out  1  host write accepted this cycle when high.
REQ-007 SHALL have port stage_wr / stage_addr / stage_data  in  1/6/32  push one {addr,data} entry.
REQ-008 SHALL have port stage_count / stage_full / overflow  out  clog2(DEPTH)+1/1/1  FIFO status, sticky drop flag.
REQ-009 SHALL have port start / abort / auto_en  in  1/1/1  load pulse, cancel pulse, enable PRISM after load.
REQ-010 SHALL have port busy / done / empty_err  out  1/1/1  sequence active, 1-cycle completion pulse, start-with-empty flag.
REQ-011 SHALL have port dbg_wr / dbg_addr / dbg_wdata  out  1/6/32  registered PRISM debug write port.
REQ-012 SHALL have port fsm_reset / fsm_enable  out  1/1  registered PRISM debug reset and run enable.

Function
REQ-013 States SHALL be IDLE, HALT, LOAD, HOLD, RUN.
REQ-014 IDLE: start with stage_count>0 -> HALT. start with count 0 -> done=1 and empty_err=1 next cycle; state stays IDLE; outputs otherwise unchanged.
REQ-015 HALT (1 cycle): fsm_enable<=0, fsm_reset<=1, busy=1 -> LOAD.
REQ-016 LOAD: host_wr has priority; a host write is issued and the loader pops nothing that cycle. Otherwise, if FIFO is non-empty, pop the head and issue it. Any issue -> HOLD. If FIFO is empty and no host_wr -> RUN.
REQ-017 Issue SHALL mean: dbg_wr=1 for exactly one cycle, with dbg_addr/dbg_wdata registered from the source in the same edge; dbg_addr/dbg_wdata are then held unchanged for HOLD further cycles.
REQ-018 HOLD SHALL count HOLD cycles, then return to LOAD (from busy) or IDLE (host write issued from IDLE).
REQ-019 RUN (1 cycle): fsm_reset<=0, fsm_enable<=auto_en, done=1, busy=0 next cycle -> IDLE.
REQ-020 host_ready SHALL be 1 in IDLE and LOAD and 0 in HALT, HOLD and RUN. host_wr with host_ready=0 SHALL be ignored.
REQ-021 An accepted host write in IDLE SHALL issue per REQ-017 with 1-cycle latency and enter HOLD.
REQ-022 stage_wr SHALL be accepted in any state, including a push during LOAD that is then loaded in the same sequence. A push while full SHALL be dropped and set overflow. A simultaneous push and pop while full SHALL succeed.
REQ-023 overflow and empty_err SHALL clear on the next accepted start.
REQ-024 abort in any non-IDLE state -> IDLE next cycle: FIFO flushed, fsm_reset stays 1, fsm_enable 0, no done pulse, dbg_wr 0. An abort in the same cycle as start SHALL win.
REQ-025 FIFO pointers SHALL wrap modulo DEPTH; stage_count SHALL range 0..DEPTH.

Reset
REQ-026 On rst SHALL set: state IDLE, FIFO empty, dbg_wr 0, dbg_addr 0, dbg_wdata 0, fsm_reset 0, fsm_enable 0, busy 0, done 0, overflow 0, empty_err 0, hold counter 0.
REQ-027 rst SHALL override every state, including mid-HOLD; stage_wr during rst SHALL be dropped.

Structure
REQ-028 The shared package prism_cfg_pkg SHALL hold the state enum, the 6-bit address and 32-bit data widths, and the default HOLD value.
REQ-029 The FIFO SHALL be the sub-module prism_cfg_fifo (push, pop, count, full, empty); the sequencer FSM and host mux SHALL live in the top module.

Verification
REQ-030 Push {0x00,0x2000_0001},{0x20,0x0500_0010}; start, auto_en=1 -> fsm_reset=1, then two dbg_wr pulses spaced 3 cycles apart with the address held, then fsm_reset=0, fsm_enable=1, one done pulse.
REQ-031 Host write {0x18,0xAB} in IDLE -> dbg_wr next cycle, address 0x18 held 2 more cycles, host_ready=0 for those cycles.
REQ-032 Host write in LOAD alongside a non-empty FIFO -> host entry issued first, FIFO entry in the next slot; stage_count decrements once.
REQ-033 Five pushes with DEPTH=4 -> stage_full=1, overflow=1, four entries loaded; a following start clears overflow.
REQ-034 start with an empty FIFO -> done and empty_err next cycle, no dbg_wr; abort during HOLD -> IDLE, stage_count=0, fsm_reset=1, no done.
REQ-035 rst asserted mid-LOAD -> all outputs at reset values next edge.
